// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (req0 wins); default is round robin.
module alu_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [3:0]       req0_a,
  input  logic [3:0]       req0_b,
  input  logic [3:0]       req1_a,
  input  logic [3:0]       req1_b,
  input  logic [1:0]       req0_sel,
  input  logic [1:0]       req1_sel,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [1:0]       alu_sel,
  input  logic [3:0]       alu_out,
  input  logic             alu_carry,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [3:0]       rsp_out,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic any_valid;
  logic gnt1;
  logic accept;
  logic op_id;

  assign any_valid = req0_valid | req1_valid;
  assign accept    = (state == IDLE) & any_valid;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign gnt1 = req1_valid & ~req0_valid;
`else
  logic last_gnt;

  // req1 wins alone, or under contention when req0 was granted last
  assign gnt1 = req1_valid & (~req0_valid | ~last_gnt);

  // remember who was granted most recently
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_gnt <= 1'b1;
    else if (accept)
      last_gnt <= gnt1;
  end
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_valid) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // handshake outputs decoded from state
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        req0_ready = any_valid & ~gnt1;
        req1_ready = gnt1;
      end
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // latch the granted op into the ALU operand registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
      op_id   <= 1'b0;
    end else if (accept) begin
      alu_a   <= gnt1 ? req1_a   : req0_a;
      alu_b   <= gnt1 ? req1_b   : req0_b;
      alu_sel <= gnt1 ? req1_sel : req0_sel;
      op_id   <= gnt1;
    end
  end

  // capture the ALU result one cycle after the operands settle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_id    <= 1'b0;
      rsp_out   <= '0;
      rsp_carry <= 1'b0;
      rsp_zero  <= 1'b0;
    end else if (state == EXEC) begin
      rsp_id    <= op_id;
      rsp_out   <= alu_out;
      rsp_carry <= alu_carry;
      rsp_zero  <= alu_zero;
    end
  end

  // per-requester accept counters, free-running wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else if (accept) begin
      if (gnt1)
        gnt_cnt1 <= gnt_cnt1 + 1'b1;
      else
        gnt_cnt0 <= gnt_cnt0 + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU model.
// Honours ALU_ARB_FIXED_PRIO_EN for the grant-order expectations.
module tb_alu_arbiter;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [3:0]       req0_a, req0_b, req1_a, req1_b;
  logic [1:0]       req0_sel, req1_sel;
  logic [3:0]       alu_a, alu_b;
  logic [1:0]       alu_sel;
  logic [3:0]       alu_out;
  logic             alu_carry, alu_zero;
  logic             rsp_valid, rsp_ready;
  logic             rsp_id;
  logic [3:0]       rsp_out;
  logic             rsp_carry, rsp_zero;
  logic [CNT_W-1:0] gnt_cnt0, gnt_cnt1;

  typedef struct packed {
    logic       id;
    logic [3:0] out;
    logic       carry;
    logic       zero;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  alu_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_a(req1_a), .req1_b(req1_b),
    .req0_sel(req0_sel), .req1_sel(req1_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_out(rsp_out),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  always #5 clk = ~clk;

  // shared ALU model
  always_comb begin
    logic [4:0] s;
    s = {1'b0, alu_a} + {1'b0, alu_b};
    alu_carry = 1'b0;
    alu_out   = 4'h0;
    case (alu_sel)
      2'b00: alu_out = alu_a & alu_b;
      2'b01: alu_out = alu_a | alu_b;
      2'b10: alu_out = alu_a ^ alu_b;
      default: begin
        alu_out   = s[3:0];
        alu_carry = s[4];
      end
    endcase
    alu_zero = (alu_out == 4'h0);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic id, input logic [3:0] o, input logic c, input logic z);
    exp_t e;
    e.id = id; e.out = o; e.carry = c; e.zero = z;
    sb.push_back(e);
  endtask

  // monitor: every response handshake pops one expectation
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      exp_t got;
      exp_t e;
      got = {rsp_id, rsp_out, rsp_carry, rsp_zero};
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_rsp actual id=%0d out=%0h c=%0d z=%0d required none",
                 got.id, got.out, got.carry, got.zero);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL rsp actual id=%0d out=%0h c=%0d z=%0d required id=%0d out=%0h c=%0d z=%0d",
                   got.id, got.out, got.carry, got.zero, e.id, e.out, e.carry, e.zero);
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp", {rsp_id, rsp_out, rsp_carry, rsp_zero}, 0);
    chk("rst_alu", {alu_a, alu_b, alu_sel}, 0);
    chk("rst_cnt", {gnt_cnt0, gnt_cnt1}, 0);
    chk("rst_ready", {req0_ready, req1_ready}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic issue(input logic who, input logic [3:0] a, input logic [3:0] b,
                       input logic [1:0] sel);
    logic ok;
    if (who) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = sel;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = sel;
    end
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = who ? req1_ready : req0_ready;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL accept_timeout actual=0 required=1 who=%0d", who);
    end
    @(posedge clk); #1;
    if (who) req1_valid = 1'b0;
    else     req0_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && sb.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout actual=%0d required=0", sb.size());
    end
  endtask

  initial begin
    logic [CNT_W-1:0] wrap_exp [5];
    logic ok;
    wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
    wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;
    req0_a = 0; req0_b = 0; req0_sel = 0;
    req1_a = 0; req1_b = 0; req1_sel = 0;

    // single ADD with carry, latency check
    do_reset();
    push(1'b0, 4'h1, 1'b1, 1'b0);
    issue(1'b0, 4'h9, 4'h8, 2'b11);
    @(negedge clk);
    chk("exec_rsp_valid", rsp_valid, 0);
    chk("exec_alu", {alu_a, alu_b, alu_sel}, {4'h9, 4'h8, 2'b11});
    @(negedge clk);
    chk("resp_rsp_valid", rsp_valid, 1);
    chk("cnt0_one", gnt_cnt0, 1);
    drain();
    chk("alu_hold", {alu_a, alu_b, alu_sel}, {4'h9, 4'h8, 2'b11});

    // continuous contention
    do_reset();
    req0_a = 4'h3; req0_b = 4'h4; req0_sel = 2'b01;
    req1_a = 4'hF; req1_b = 4'h1; req1_sel = 2'b11;
`ifdef ALU_ARB_FIXED_PRIO_EN
    repeat (4) push(1'b0, 4'h7, 1'b0, 1'b0);
`else
    push(1'b0, 4'h7, 1'b0, 1'b0);
    push(1'b1, 4'h0, 1'b1, 1'b1);
    push(1'b0, 4'h7, 1'b0, 1'b0);
    push(1'b1, 4'h0, 1'b1, 1'b1);
`endif
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();
`ifdef ALU_ARB_FIXED_PRIO_EN
    chk("rr_cnt0", gnt_cnt0, 0);
    chk("rr_cnt1", gnt_cnt1, 0);
`else
    chk("rr_cnt0", gnt_cnt0, 2);
    chk("rr_cnt1", gnt_cnt1, 2);
`endif

    // backpressure: AND result held, no accept
    do_reset();
    rsp_ready = 1'b0;
    push(1'b1, 4'h0, 1'b0, 1'b1);
    issue(1'b1, 4'h5, 4'hA, 2'b00);
    req0_valid = 1'b1; req0_a = 4'h2; req0_b = 4'h2; req0_sel = 2'b10;
    push(1'b0, 4'h0, 1'b0, 1'b1);
    @(negedge clk);
    chk("exec_ready", {req0_ready, req1_ready}, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp", {rsp_valid, rsp_id, rsp_out, rsp_carry, rsp_zero},
          {1'b1, 1'b1, 4'h0, 1'b0, 1'b1});
      chk("bp_ready", {req0_ready, req1_ready}, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = req0_ready;
    end
    chk("bp_next_accept", ok, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    drain();

    // counter wrap with 2-bit counters
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push(1'b0, 4'(i + 1), 1'b0, 1'b0);
      issue(1'b0, 4'(i), 4'h1, 2'b11);
      @(negedge clk);
      chk("cnt_wrap", gnt_cnt0, wrap_exp[i]);
    end
    drain();

    // reset while holding a response
    do_reset();
    rsp_ready = 1'b0;
    issue(1'b0, 4'h3, 4'h5, 2'b11);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_valid", {rsp_valid, rsp_out}, {1'b1, 4'h8});
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_rsp", {rsp_id, rsp_out, rsp_carry, rsp_zero}, 0);
    chk("mid_rst_alu", {alu_a, alu_b, alu_sel, gnt_cnt0, gnt_cnt1}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 4'h1; req0_b = 4'h2; req0_sel = 2'b01;
    req1_valid = 1'b1; req1_a = 4'h4; req1_b = 4'h4; req1_sel = 2'b11;
    push(1'b0, 4'h3, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_rst_grant", {req0_ready, req1_ready}, 2'b10);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
